// File: rtl/user_out_port_pkg.sv
// Shared constants for the user output port: register-file address map
// and data width of the CPU write bus.
`ifndef USER_OUT_PORT_PKG_SV
`define USER_OUT_PORT_PKG_SV
package user_out_port_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_ADDR_W = 2;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_USER = 2'd3;

endpackage
`endif

// File: rtl/user_out_port_if.sv
// Bus bundle for the user output port: the snooped CPU register write bus
// plus the consumer-side valid/ready handshake and FIFO status.
// master = CPU + consumer side, slave = user_out_port.
interface user_out_port_if
  import user_out_port_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] a;
  logic                  ce;
  logic [WIDTH-1:0]      in;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  full;
  logic [LVL_W-1:0]      level;

  modport master (
    output a, ce, in, out_ready,
    input  out_data, out_valid, full, level
  );

  modport slave (
    input  a, ce, in, out_ready,
    output out_data, out_valid, full, level
  );
endinterface

// File: rtl/user_out_port_sync_fifo.sv
// Synchronous FIFO: registered pointers and count, unreset storage array.
// Head data reads as zero while empty so the output is deterministic.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for pointers and count; pointers wrap naturally at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = (count_q != CNT_W'(0)) ? mem_q[rd_ptr_q] : WIDTH'(0);
  assign count = count_q;
endmodule

// File: rtl/user_out_port.sv
// User output port: snoops CPU writes to the user register address,
// queues them in a FIFO and hands them to the consumer via valid/ready.
// Optional sticky overflow flag enabled by macro USER_OUT_PORT_OVF_EN.
module user_out_port
  import user_out_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  user_out_port_if.slave bus
`ifdef USER_OUT_PORT_OVF_EN
  ,
  output logic overflow
`endif
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             wr_s;
  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic             valid_s;
  logic [CNT_W-1:0] count_s;
  logic [WIDTH-1:0] rdata_s;

  assign valid_s = (count_s != CNT_W'(0));
  assign full_s  = (count_s == CNT_W'(DEPTH));
  assign wr_s    = bus.ce && (bus.a == REG_ADDR_USER);
  assign pop_s   = valid_s && bus.out_ready;
  // A write into a full FIFO only lands if the head leaves on the same edge.
  assign push_s  = wr_s && (!full_s || pop_s);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (bus.in),
    .pop   (pop_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  assign bus.out_data  = rdata_s;
  assign bus.out_valid = valid_s;
  assign bus.full      = full_s;
  assign bus.level     = count_s;

`ifdef USER_OUT_PORT_OVF_EN
  logic overflow_q, overflow_d;

  // Overflow next-state: set on a dropped write, otherwise hold.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Sticky overflow register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif
endmodule
